// File: rtl/axi_mem_pkg.sv
// Shared AXI response/burst codes and FSM state types for the burst memory responder.
package axi_mem_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;
endpackage

// File: rtl/axi_interface_if.sv
// AXI4 read (AR/R) and write (AW/W/B) channel bundle with responder-side modports.
interface axi_interface_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport rd_slv (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

    modport wr_slv (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_mem_array.sv
// Simple dual-port RAM: one registered read port, one byte-enabled write port, read-before-write.
module axi_mem_array #(
    parameter int DATA_W      = 64,
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                clk_i,
    input  logic                re_i,
    input  logic [AW-1:0]       raddr_i,
    output logic [DATA_W-1:0]   rdata_o,
    input  logic                we_i,
    input  logic [AW-1:0]       waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i
);
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Read data holds between enables so the responder can stall a beat on it.
    always_ff @(posedge clk_i) begin
        if (re_i) rdata_q <= mem_q[raddr_i];
        if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_burst_mem_responder.sv
// AXI4 burst memory responder with independent read and write FSMs over axi_mem_array.
// Define AXI_MEM_RESP_ERR_EN for SLVERR on out-of-range/size-mismatch beats; otherwise the index wraps.
//   state   | meaning
//   R_IDLE  | arready high, waiting for AR
//   R_BURST | presenting read beats until rlast handshake
//   W_IDLE  | awready high, waiting for AW
//   W_DATA  | wready high, writing beats 0..awlen
//   W_RESP  | bvalid high until bready
module axi_burst_mem_responder
    import axi_mem_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int DEPTH_WORDS = 4096,
    parameter int ID_W        = 4,
    parameter int ADDR_W      = 32
) (
    input logic             clk,
    input logic             rst,
    axi_interface_if.rd_slv axi_read_in,
    axi_interface_if.wr_slv axi_write_in
);
    localparam int NB                = DATA_W / 8;
    localparam int AW                = $clog2(DEPTH_WORDS);
    localparam int SHIFT             = $clog2(NB);
    localparam logic [2:0] SIZE_LOG2 = 3'(SHIFT);
`ifdef AXI_MEM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
        return addr >> SHIFT;
    endfunction

    function automatic logic [AW-1:0] ram_idx(input logic [ADDR_W-1:0] idx);
        return AW'(idx % ADDR_W'(DEPTH_WORDS));
    endfunction

    function automatic logic beat_err(input logic [ADDR_W-1:0] idx, input logic [2:0] size);
        return ERR_EN && ((idx >= ADDR_W'(DEPTH_WORDS)) || (size != SIZE_LOG2));
    endfunction

    r_state_e           r_state_q, r_state_d;
    logic [ID_W-1:0]    rid_q, rid_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d, r_next_idx;
    logic [7:0]         rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [2:0]         rsize_q, rsize_d;
    logic [1:0]         rburst_q, rburst_d;
    logic               rvalid_q, rvalid_d, rerr_q, rerr_d;

    w_state_e           w_state_q, w_state_d;
    logic [ID_W-1:0]    wid_q, wid_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [7:0]         wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [2:0]         wsize_q, wsize_d;
    logic [1:0]         wburst_q, wburst_d;
    logic               werr_q, werr_d, w_last, w_berr;

    logic               ram_re, ram_we;
    logic [AW-1:0]      ram_raddr;
    logic [DATA_W-1:0]  ram_rdata;

    always_comb begin
        r_state_d  = r_state_q;
        rid_d      = rid_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rsize_d    = rsize_q;
        rburst_d   = rburst_q;
        rbeat_d    = rbeat_q;
        rvalid_d   = rvalid_q;
        rerr_d     = rerr_q;
        ram_re     = 1'b0;
        r_next_idx = word_idx(axi_read_in.araddr);
        unique case (r_state_q)
            R_IDLE: begin
                if (axi_read_in.arvalid) begin
                    r_state_d = R_BURST;
                    rid_d     = axi_read_in.arid;
                    rlen_d    = axi_read_in.arlen;
                    rsize_d   = axi_read_in.arsize;
                    rburst_d  = axi_read_in.arburst;
                    rbeat_d   = 8'd0;
                    rvalid_d  = 1'b1;
                    raddr_d   = r_next_idx;
                    rerr_d    = beat_err(r_next_idx, axi_read_in.arsize);
                    ram_re    = 1'b1;
                end
            end
            R_BURST: begin
                r_next_idx = (rburst_q == BURST_FIXED) ? raddr_q : raddr_q + 1'b1;
                if (rvalid_q && axi_read_in.rready) begin
                    if (rbeat_q == rlen_q) begin
                        r_state_d = R_IDLE;
                        rvalid_d  = 1'b0;
                    end else begin
                        // Prefetch the next beat so beats stream back-to-back.
                        raddr_d = r_next_idx;
                        rbeat_d = rbeat_q + 8'd1;
                        rerr_d  = beat_err(r_next_idx, rsize_q);
                        ram_re  = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        ram_raddr = ram_idx(r_next_idx);
    end

    always_comb begin
        w_state_d = w_state_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        wbeat_d   = wbeat_q;
        werr_d    = werr_q;
        w_last    = (wbeat_q == wlen_q);
        w_berr    = beat_err(waddr_q, wsize_q);
        ram_we    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (axi_write_in.awvalid) begin
                    w_state_d = W_DATA;
                    wid_d     = axi_write_in.awid;
                    waddr_d   = word_idx(axi_write_in.awaddr);
                    wlen_d    = axi_write_in.awlen;
                    wsize_d   = axi_write_in.awsize;
                    wburst_d  = axi_write_in.awburst;
                    wbeat_d   = 8'd0;
                    werr_d    = 1'b0;
                end
            end
            W_DATA: begin
                if (axi_write_in.wvalid) begin
                    ram_we  = !w_berr;
                    werr_d  = werr_q | w_berr | (axi_write_in.wlast != w_last);
                    waddr_d = (wburst_q == BURST_FIXED) ? waddr_q : waddr_q + 1'b1;
                    wbeat_d = wbeat_q + 8'd1;
                    if (w_last) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi_write_in.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rbeat_q   <= '0;
            rvalid_q  <= 1'b0;
            rerr_q    <= 1'b0;
            w_state_q <= W_IDLE;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rbeat_q   <= rbeat_d;
            rvalid_q  <= rvalid_d;
            rerr_q    <= rerr_d;
            w_state_q <= w_state_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
        end
    end

    axi_mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem (
        .clk_i   (clk),
        .re_i    (ram_re && !rst),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata),
        .we_i    (ram_we && !rst),
        .waddr_i (ram_idx(waddr_q)),
        .wdata_i (axi_write_in.wdata),
        .wstrb_i (axi_write_in.wstrb)
    );

    assign axi_read_in.arready  = (r_state_q == R_IDLE);
    assign axi_read_in.rvalid   = rvalid_q;
    assign axi_read_in.rdata    = (rvalid_q && !rerr_q) ? ram_rdata : '0;
    assign axi_read_in.rresp    = (rvalid_q && rerr_q) ? RESP_SLVERR : RESP_OKAY;
    assign axi_read_in.rlast    = rvalid_q && (rbeat_q == rlen_q);
    assign axi_read_in.rid      = rvalid_q ? rid_q : '0;

    assign axi_write_in.awready = (w_state_q == W_IDLE);
    assign axi_write_in.wready  = (w_state_q == W_DATA);
    assign axi_write_in.bvalid  = (w_state_q == W_RESP);
    assign axi_write_in.bid     = (w_state_q == W_RESP) ? wid_q : '0;
    assign axi_write_in.bresp   = ((w_state_q == W_RESP) && werr_q) ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: tb/tb_axi_burst_mem_responder.sv
// Directed bench for axi_burst_mem_responder: reference memory model plus R/B scoreboards.
module tb_axi_burst_mem_responder;
    import axi_mem_pkg::*;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 4096;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
`ifdef AXI_MEM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0]     data;
        logic [1:0]      resp;
        logic            last;
        logic [ID_W-1:0] id;
    } r_beat_t;

    typedef struct packed {
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
    } b_resp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_interface_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi_if ();

    axi_burst_mem_responder #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH),
        .ID_W        (ID_W),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .axi_read_in  (axi_if),
        .axi_write_in (axi_if)
    );

    r_beat_t     r_exp[$];
    b_resp_t     b_exp[$];
    logic [63:0] model [DEPTH];
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input int word, input int len,
                            input logic [1:0] burst, input logic [7:0] strb,
                            input int wlast_beat, input logic [63:0] dbase);
        bit          err_any;
        bit          rdy;
        int          guard;
        int          idx;
        logic [63:0] d;
        b_resp_t     be;
        err_any = 1'b0;
        for (int i = 0; i <= len; i++) begin
            idx = (burst == BURST_FIXED) ? word : word + i;
            d   = dbase + 64'(i);
            if (ERR_EN && idx >= DEPTH) err_any = 1'b1;
            else begin
                for (int b = 0; b < 8; b++)
                    if (strb[b]) model[idx % DEPTH][b*8 +: 8] = d[b*8 +: 8];
            end
        end
        be.id   = id;
        be.resp = (err_any || (wlast_beat != len)) ? RESP_SLVERR : RESP_OKAY;
        b_exp.push_back(be);

        axi_if.awid    = id;
        axi_if.awaddr  = 32'(word * 8);
        axi_if.awlen   = 8'(len);
        axi_if.awsize  = 3'd3;
        axi_if.awburst = burst;
        axi_if.awvalid = 1'b1;
        guard = 0;
        do begin
            rdy = axi_if.awready;
            tick();
            guard++;
        end while (!rdy && guard < 50);
        axi_if.awvalid = 1'b0;
        check("aw_handshake", 64'(rdy), 64'd1);

        for (int i = 0; i <= len; i++) begin
            axi_if.wdata  = dbase + 64'(i);
            axi_if.wstrb  = strb;
            axi_if.wlast  = (i == wlast_beat);
            axi_if.wvalid = 1'b1;
            guard = 0;
            do begin
                rdy = axi_if.wready;
                tick();
                guard++;
            end while (!rdy && guard < 50);
            if (!rdy) check("w_beat_timeout", 64'(rdy), 64'd1);
        end
        axi_if.wvalid = 1'b0;
        axi_if.wlast  = 1'b0;
        check("wready_after_last_beat", 64'(axi_if.wready), 64'd0);

        axi_if.bready = 1'b1;
        guard = 0;
        while (!axi_if.bvalid && guard < 50) begin
            tick();
            guard++;
        end
        check("b_valid", 64'(axi_if.bvalid), 64'd1);
        be = b_exp.pop_front();
        check("b_id", 64'(axi_if.bid), 64'(be.id));
        check("b_resp", 64'(axi_if.bresp), 64'(be.resp));
        tick();
        axi_if.bready = 1'b0;
        check("b_done_bvalid", 64'(axi_if.bvalid), 64'd0);
        check("awready_after_b", 64'(axi_if.awready), 64'd1);
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input int word, input int len,
                           input logic [1:0] burst, input bit toggle, input int abort_after);
        bit      rdy;
        bit      hs;
        bit      aborted;
        int      guard;
        int      idx;
        int      cyc;
        int      popped;
        r_beat_t be;
        for (int b = 0; b <= len; b++) begin
            idx     = (burst == BURST_FIXED) ? word : word + b;
            be.id   = id;
            be.last = (b == len);
            if (ERR_EN && idx >= DEPTH) begin
                be.data = '0;
                be.resp = RESP_SLVERR;
            end else begin
                be.data = model[idx % DEPTH];
                be.resp = RESP_OKAY;
            end
            r_exp.push_back(be);
        end

        axi_if.arid    = id;
        axi_if.araddr  = 32'(word * 8);
        axi_if.arlen   = 8'(len);
        axi_if.arsize  = 3'd3;
        axi_if.arburst = burst;
        axi_if.arvalid = 1'b1;
        guard = 0;
        do begin
            rdy = axi_if.arready;
            tick();
            guard++;
        end while (!rdy && guard < 50);
        axi_if.arvalid = 1'b0;
        check("ar_handshake", 64'(rdy), 64'd1);
        check("r_first_latency", 64'(axi_if.rvalid), 64'd1);

        cyc     = 0;
        popped  = 0;
        aborted = 1'b0;
        while (r_exp.size() > 0 && cyc < 3000) begin
            axi_if.rready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (axi_if.rvalid) begin
                check("r_data", axi_if.rdata, r_exp[0].data);
                check("r_resp", 64'(axi_if.rresp), 64'(r_exp[0].resp));
                check("r_last", 64'(axi_if.rlast), 64'(r_exp[0].last));
                check("r_id", 64'(axi_if.rid), 64'(r_exp[0].id));
            end
            hs = axi_if.rvalid && axi_if.rready;
            tick();
            cyc++;
            if (hs) begin
                void'(r_exp.pop_front());
                popped++;
            end
            if (abort_after > 0 && popped == abort_after && !aborted) begin
                aborted       = 1'b1;
                axi_if.rready = 1'b0;
                rst = 1'b1;
                tick();
                check("rst_mid_rvalid", 64'(axi_if.rvalid), 64'd0);
                check("rst_mid_rlast", 64'(axi_if.rlast), 64'd0);
                check("rst_mid_bvalid", 64'(axi_if.bvalid), 64'd0);
                rst = 1'b0;
                check("rst_mid_arready", 64'(axi_if.arready), 64'd1);
                check("rst_mid_awready", 64'(axi_if.awready), 64'd1);
                r_exp.delete();
            end
        end
        axi_if.rready = 1'b0;
        check("r_burst_complete", 64'(r_exp.size()), 64'd0);
        r_exp.delete();
        if (!aborted) begin
            check("r_done_rvalid", 64'(axi_if.rvalid), 64'd0);
            check("r_done_arready", 64'(axi_if.arready), 64'd1);
        end
    endtask

    initial begin
        axi_if.arid = '0; axi_if.araddr = '0; axi_if.arlen = '0; axi_if.arsize = '0;
        axi_if.arburst = '0; axi_if.arvalid = 1'b0; axi_if.rready = 1'b0;
        axi_if.awid = '0; axi_if.awaddr = '0; axi_if.awlen = '0; axi_if.awsize = '0;
        axi_if.awburst = '0; axi_if.awvalid = 1'b0; axi_if.wdata = '0; axi_if.wstrb = '0;
        axi_if.wlast = 1'b0; axi_if.wvalid = 1'b0; axi_if.bready = 1'b0;

        rst = 1'b1;
        repeat (3) tick();
        check("rst_rvalid", 64'(axi_if.rvalid), 64'd0);
        check("rst_bvalid", 64'(axi_if.bvalid), 64'd0);
        check("rst_wready", 64'(axi_if.wready), 64'd0);
        check("rst_rlast", 64'(axi_if.rlast), 64'd0);
        check("rst_rdata", axi_if.rdata, 64'd0);
        check("rst_rid", 64'(axi_if.rid), 64'd0);
        check("rst_bid", 64'(axi_if.bid), 64'd0);
        check("rst_rresp", 64'(axi_if.rresp), 64'd0);
        check("rst_bresp", 64'(axi_if.bresp), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_arready", 64'(axi_if.arready), 64'd1);
        check("post_rst_awready", 64'(axi_if.awready), 64'd1);
        tick();

        // 16-beat INCR write at byte 0x40 then read back with full and toggling rready.
        do_write(4'd3, 8, 15, BURST_INCR, 8'hFF, 15, 64'd0);
        do_read(4'd5, 8, 15, BURST_INCR, 1'b0, 0);
        do_read(4'd6, 8, 15, BURST_INCR, 1'b1, 0);

        // Partial strobe over a zeroed word, then an all-zero strobe that must not write.
        do_write(4'd1, 0, 1, BURST_INCR, 8'hFF, 1, 64'd0);
        do_write(4'd2, 0, 0, BURST_INCR, 8'h0F, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        do_read(4'd2, 0, 0, BURST_INCR, 1'b0, 0);
        check("strb_0f_model", model[0], 64'h0000_0000_FFFF_FFFF);
        do_write(4'd4, 0, 0, BURST_INCR, 8'h00, 0, 64'h1234);
        do_read(4'd4, 0, 1, BURST_INCR, 1'b0, 0);

        // FIXED bursts stay on one word.
        do_write(4'd7, 100, 3, BURST_FIXED, 8'hFF, 3, 64'hA0);
        do_read(4'd8, 100, 2, BURST_FIXED, 1'b1, 0);

        // Maximum 256-beat burst.
        do_write(4'd9, 256, 255, BURST_INCR, 8'hFF, 255, 64'h1000);
        do_read(4'd10, 256, 255, BURST_INCR, 1'b0, 0);

        // Top of memory: wraps by default, SLVERR with zero data when checking is enabled.
        do_write(4'd11, DEPTH - 2, 1, BURST_INCR, 8'hFF, 1, 64'hD0);
        do_read(4'd12, DEPTH - 2, 3, BURST_INCR, 1'b0, 0);

        // wlast early and missing: all beats still accepted, SLVERR response.
        do_write(4'd13, 40, 3, BURST_INCR, 8'hFF, 1, 64'hB0);
        do_read(4'd14, 40, 3, BURST_INCR, 1'b0, 0);
        do_write(4'd14, 50, 1, BURST_INCR, 8'hFF, -1, 64'hC0);

        // Reset in the middle of a read; memory must survive.
        do_read(4'd15, 8, 15, BURST_INCR, 1'b0, 3);
        do_read(4'd0, 8, 15, BURST_INCR, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_burst_mem_responder.md
AXI_BURST_MEM_RESPONDER -- requirements
Module: axi_burst_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data bus width in bits.
REQ-002 SHALL have parameter DEPTH_WORDS, default 4096, memory depth in DATA_W words.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-005 SHALL have port axi_read_in, axi_interface_if.rd_slv, AR/R channels, responder side.
REQ-006 SHALL have port axi_write_in, axi_interface_if.wr_slv, AW/W/B channels, responder side.

Function
REQ-007 SHALL run the read FSM {R_IDLE, R_BURST} and the write FSM {W_IDLE, W_DATA, W_RESP} independently and concurrently.
REQ-008 SHALL drive arready=1 only in R_IDLE; on arvalid&&arready it latches arid, araddr, arlen, arsize and arburst, then enters R_BURST.
REQ-009 SHALL present the first rvalid exactly 1 cycle after the AR handshake (registered RAM read); each later beat follows 1 cycle after the previous rvalid&&rready.
REQ-010 SHALL hold rdata, rresp, rlast and rid stable while rvalid=1 and rready=0.
REQ-011 SHALL assert rlast on beat arlen, return to R_IDLE after that beat's handshake, and echo rid=arid.
REQ-012 SHALL treat burst 2'b00 (FIXED) as a constant address; every other burst code advances the address by one word per beat (INCR).
REQ-013 SHALL compute the word index as addr/(DATA_W/8); the beat counter is 8 bits, so arlen=255 yields 256 beats.
REQ-014 SHALL drive awready=1 only in W_IDLE and wready=1 only in W_DATA; on the AW handshake it latches awid, awaddr, awlen, awsize and awburst.
REQ-015 SHALL write each accepted W beat in the same cycle with byte enables from wstrb; wstrb=0 leaves memory unchanged.
REQ-016 SHALL leave W_DATA after beat awlen, regardless of wlast; a wlast mismatch (early or missing) forces bresp=SLVERR.
REQ-017 SHALL, in W_RESP, hold bvalid=1 with bid=awid until bready, then return to W_IDLE.
REQ-018 SHALL, on a same-cycle read and write of one word, return the pre-write data on the read.
REQ-019 SHALL drive OKAY (2'b00) on rresp/bresp unless an error is defined in REQ-024.

Reset
REQ-020 SHALL, while rst=1, force R_IDLE and W_IDLE, rvalid=0, bvalid=0, rlast=0, wready=0, and rdata/rid/bid/rresp/bresp=0.
REQ-021 SHALL drive arready=1 and awready=1 in the first cycle after rst deasserts.
REQ-022 SHALL abort any in-flight burst when rst asserts mid-burst, retaining memory contents (no clear) and issuing no response for the aborted burst.

Configuration
REQ-023 SHALL have the macro AXI_MEM_RESP_ERR_EN select error checking.
REQ-024 SHALL, with AXI_MEM_RESP_ERR_EN defined, respond SLVERR (2'b10) per beat when the word index is >= DEPTH_WORDS or arsize/awsize != log2(DATA_W/8); such read beats return rdata=0, such write beats are dropped, and bresp is SLVERR if any beat errored.
REQ-025 SHALL, without AXI_MEM_RESP_ERR_EN, wrap the word index modulo DEPTH_WORDS, ignore size, and always respond OKAY (except REQ-016).

Structure
REQ-026 SHALL place AXI resp codes, burst codes and both FSM state typedefs in package axi_mem_pkg.
REQ-027 SHALL instantiate one sub-module, axi_mem_array: simple dual-port RAM (1 read, 1 byte-enabled write), registered read, read-before-write.

Verification
REQ-028 SHALL pass: write araddr 0x40, awlen=15, wdata=i, wstrb=0xFF; then read same, arlen=15 -> 16 beats rdata=0..15, rlast on beat 15 only, bresp=OKAY, rid=arid.
REQ-029 SHALL pass: a read burst with rready toggling 1/0 each cycle -> no beat lost or duplicated, R signals stable while stalled.
REQ-030 SHALL pass: a write with wstrb=0x0F over 0xFFFF_FFFF_FFFF_FFFF onto word 0 preset to 0 -> readback 0x0000_0000_FFFF_FFFF.
REQ-031 SHALL pass: with AXI_MEM_RESP_ERR_EN, read at word DEPTH_WORDS-2 with arlen=3 -> beats 0-1 OKAY, beats 2-3 SLVERR with rdata=0.
REQ-032 SHALL pass: awlen=3 with wlast on beat 1 -> 4 beats accepted, bresp=SLVERR; rst asserted mid-read -> rvalid=0 next cycle, arready=1 after release.
